// File: rtl/int_gen_pkg.sv
// Shared types and constants for the interrupt request generator:
// FSM encoding, register offsets and STATUS field positions.
package int_gen_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StGap    = 2'd2
    } irq_state_e;

    localparam logic [1:0] RegPending = 2'd0;
    localparam logic [1:0] RegEnable  = 2'd1;
    localparam logic [1:0] RegStatus  = 2'd2;
    localparam logic [1:0] RegSwset   = 2'd3;

    localparam int unsigned StatusStateLsb = 0;
    localparam int unsigned StatusIdxLsb   = 8;
    localparam int unsigned StatusIrqBit   = 16;

    // Index of the lowest set bit, 0 when none are set.
    function automatic logic [4:0] lowest_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/int_pending_reg.sv
// Per-source pending latch: set from events/software, write-1-to-clear,
// with a set winning over a clear of the same bit in the same cycle.
module int_pending_reg #(
    parameter int unsigned NSRC = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NSRC-1:0] set_i,
    input  logic [NSRC-1:0] clr_i,
    output logic [NSRC-1:0] pending_o,
    output logic            cleared_o
);

    logic [NSRC-1:0] pending_q, pending_d;

    always_comb begin
        pending_d = (pending_q & ~clr_i) | set_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    // Only bits that actually drop count; a simultaneous set keeps the bit alive.
    assign cleared_o = |(pending_q & clr_i & ~set_i);

endmodule

// File: rtl/int_request_gen.sv
// Memory-mapped interrupt request generator: pending/enable registers and an
// edge-friendly request FSM guaranteeing a low gap before each rising edge.
module int_request_gen
    import int_gen_pkg::*;
#(
    parameter int unsigned NSRC    = 8,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] src_evt,
    input  logic            io_we,
    input  logic [1:0]      io_wadr,
    input  logic [31:0]     io_wdata,
    input  logic            io_re,
    input  logic [1:0]      io_radr,
    output logic [31:0]     io_rdata,
    output logic            interrupt_0
);

    localparam int unsigned CntW = $clog2(GAP_CYC + 1);

    irq_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            irq_q;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] pending, masked, w1c, swset;
    logic            cleared, req;
    logic [31:0]     rdata_q, rdata_d, status;
    logic            unused_wdata;

    assign unused_wdata = ^io_wdata;

    assign w1c   = (io_we && io_wadr == RegPending) ? io_wdata[NSRC-1:0] : '0;
    assign swset = (io_we && io_wadr == RegSwset) ? io_wdata[NSRC-1:0] : '0;

    int_pending_reg #(
        .NSRC (NSRC)
    ) u_pending (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .set_i     (src_evt | swset),
        .clr_i     (w1c),
        .pending_o (pending),
        .cleared_o (cleared)
    );

    assign masked = pending & enable_q;
    assign req    = |masked;

    always_comb begin
        enable_d = enable_q;
        if (io_we && io_wadr == RegEnable) enable_d = io_wdata[NSRC-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable_q <= '0;
        end else begin
            enable_q <= enable_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        state_q <= StAssert;
                        irq_q   <= 1'b1;
                    end
                end
                StAssert: begin
                    // A W1C that drops a bit forces a fresh edge for what remains.
                    if (!req || cleared) begin
                        state_q <= StGap;
                        irq_q   <= 1'b0;
                        cnt_q   <= CntW'(GAP_CYC);
                    end
                end
                StGap: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        status                            = '0;
        status[StatusStateLsb +: 2]       = state_q;
        status[StatusIdxLsb +: 5]         = lowest_idx(32'(masked));
        status[StatusIrqBit]              = irq_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (io_re) begin
            unique case (io_radr)
                RegPending: rdata_d = 32'(pending);
                RegEnable:  rdata_d = 32'(enable_q);
                RegStatus:  rdata_d = status;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign io_rdata    = rdata_q;
    assign interrupt_0 = irq_q;

endmodule

// File: tb/tb_int_request_gen.sv
// Self-checking bench for int_request_gen: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_int_request_gen;

    localparam int unsigned NSRC    = 8;
    localparam int unsigned GAP_CYC = 2;
    localparam logic [31:0] Mask    = 32'hFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NSRC-1:0] src_evt = '0;
    logic            io_we = 1'b0;
    logic [1:0]      io_wadr = '0;
    logic [31:0]     io_wdata = '0;
    logic            io_re = 1'b0;
    logic [1:0]      io_radr = '0;
    logic [31:0]     io_rdata;
    logic            interrupt_0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pend = '0;
    logic [31:0] m_en = '0;
    logic [31:0] m_rdata = '0;
    bit          m_asserted = 1'b0;
    int          m_gap = 0;

    always #5 clk = ~clk;

    int_request_gen #(
        .NSRC    (NSRC),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_evt     (src_evt),
        .io_we       (io_we),
        .io_wadr     (io_wadr),
        .io_wdata    (io_wdata),
        .io_re       (io_re),
        .io_radr     (io_radr),
        .io_rdata    (io_rdata),
        .interrupt_0 (interrupt_0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        int idx;
        logic [31:0] m;
        logic [1:0] code;
        m = m_pend & m_en;
        idx = 0;
        for (int i = 31; i >= 0; i--) if (m[i]) idx = i;
        code = m_asserted ? 2'd1 : (m_gap > 0 ? 2'd2 : 2'd0);
        return (32'(idx) << 8) | (32'(m_asserted) << 16) | 32'(code);
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [31:0] evt, sw, w1c;
        bit req, cleared;
        if (!rst_n) begin
            m_pend = '0; m_en = '0; m_rdata = '0; m_asserted = 0; m_gap = 0;
            return;
        end
        req = (m_pend & m_en) != 0;
        if (io_re) begin
            case (io_radr)
                2'd0: m_rdata = m_pend;
                2'd1: m_rdata = m_en;
                2'd2: m_rdata = model_status();
                default: m_rdata = '0;
            endcase
        end
        evt = 32'(src_evt);
        sw  = (io_we && io_wadr == 2'd3) ? (io_wdata & Mask) : '0;
        w1c = (io_we && io_wadr == 2'd0) ? (io_wdata & Mask) : '0;
        cleared = (m_pend & w1c & ~(evt | sw)) != 0;
        m_pend = (m_pend & ~w1c) | evt | sw;
        if (io_we && io_wadr == 2'd1) m_en = io_wdata & Mask;
        if (m_asserted) begin
            if (!req || cleared) begin
                m_asserted = 0;
                m_gap = GAP_CYC;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req) begin
            m_asserted = 1;
        end
    endtask

    task automatic cycle(input logic [NSRC-1:0] evt, input logic we, input logic [1:0] wadr,
                         input logic [31:0] wdata, input logic re, input logic [1:0] radr,
                         input logic rst);
        src_evt = evt; io_we = we; io_wadr = wadr; io_wdata = wdata;
        io_re = re; io_radr = radr; rst_n = rst;
        @(posedge clk);
        model_step();
        #1;
        check("irq_model", 32'(interrupt_0), 32'(m_asserted));
        check("rdata_model", io_rdata, m_rdata);
    endtask

    task automatic idle();
        cycle('0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] data);
        cycle('0, 1'b1, adr, data, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic rd(input logic [1:0] adr);
        cycle('0, 1'b0, 2'd0, '0, 1'b1, adr, 1'b1);
    endtask

    task automatic pulse(input logic [NSRC-1:0] evt);
        cycle(evt, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        // Reset
        cycle('0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
        cycle('0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
        check("reset_irq", 32'(interrupt_0), 32'd0);
        check("reset_rdata", io_rdata, 32'd0);
        for (int k = 0; k < 4; k++) begin
            rd(2'(k));
            check("reset_reg", io_rdata, 32'd0);
        end

        // Single source assert / clear
        wr(2'd1, 32'h01);
        pulse(8'h01);
        check("s1_irq_t1", 32'(interrupt_0), 32'd0);
        idle();
        check("s1_irq_t2", 32'(interrupt_0), 32'd1);
        rd(2'd0);
        check("s1_pending", io_rdata, 32'h01);
        wr(2'd0, 32'h01);
        check("s1_clr_t1", 32'(interrupt_0), 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle();
            check("s1_stays_low", 32'(interrupt_0), 32'd0);
        end

        // Two sources, clear one: exact gap then re-assert
        wr(2'd1, 32'h03);
        pulse(8'h03);
        idle();
        check("s2_irq_on", 32'(interrupt_0), 32'd1);
        wr(2'd0, 32'h01);
        check("s2_gap1", 32'(interrupt_0), 32'd0);
        idle();
        check("s2_gap2", 32'(interrupt_0), 32'd0);
        idle();
        check("s2_idle", 32'(interrupt_0), 32'd0);
        idle();
        check("s2_reassert", 32'(interrupt_0), 32'd1);
        rd(2'd2);
        check("s2_status", io_rdata, 32'h0001_0101);
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'h00);
        for (int k = 0; k < 3; k++) idle();

        // Disabled source latches; enabling raises request
        pulse(8'h20);
        idle();
        check("s3_no_req", 32'(interrupt_0), 32'd0);
        rd(2'd0);
        check("s3_pending", io_rdata, 32'h20);
        wr(2'd1, 32'h20);
        check("s3_en_t1", 32'(interrupt_0), 32'd0);
        idle();
        check("s3_en_t2", 32'(interrupt_0), 32'd1);
        wr(2'd0, 32'h20);
        wr(2'd1, 32'h00);
        for (int k = 0; k < 3; k++) idle();

        // Set beats W1C; SWSET
        cycle(8'h04, 1'b1, 2'd0, 32'h04, 1'b0, 2'd0, 1'b1);
        rd(2'd0);
        check("s4_set_wins", io_rdata, 32'h04);
        wr(2'd0, 32'h04);
        wr(2'd1, 32'h80);
        wr(2'd3, 32'h80);
        check("s4_sw_t1", 32'(interrupt_0), 32'd0);
        idle();
        check("s4_sw_t2", 32'(interrupt_0), 32'd1);
        rd(2'd3);
        check("s4_swset_rd", io_rdata, 32'h0);
        rd(2'd0);
        check("s4_pending", io_rdata, 32'h80);

        // Reset while asserted
        cycle('0, 1'b0, 2'd0, '0, 1'b0, 2'd0, 1'b0);
        check("s5_rst_irq", 32'(interrupt_0), 32'd0);
        rd(2'd0);
        check("s5_rst_pend", io_rdata, 32'h0);
        rd(2'd1);
        check("s5_rst_en", io_rdata, 32'h0);
        wr(2'd1, 32'h01);
        pulse(8'h01);
        idle();
        check("s5_after_rst", 32'(interrupt_0), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [NSRC-1:0] evt;
            logic we, re, rst;
            evt = NSRC'($urandom & $urandom & $urandom);
            we  = ($urandom_range(0, 2) == 0);
            re  = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 199) != 0);
            cycle(evt, we, 2'($urandom_range(0, 3)), $urandom, re, 2'($urandom_range(0, 3)),
                  rst);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
